// File: rtl/ha_serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder that drives one external half-adder cell.
// Each bit takes two passes: a^b first, then the partial sum with the running carry.
module ha_serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy,
    output logic             ha_a,
    output logic             ha_b,
    input  logic             ha_sum,
    input  logic             ha_carry
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADD_AB  = 2'd1,
        ADD_CIN = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              cy_q, cy_d;
    logic              s0_q, s0_d;
    logic              c0_q, c0_d;
    logic              cout_q, cout_d;
    logic [WIDTH-1:0]  result_shift;

    // Shift-in form works for WIDTH=1, where a [WIDTH-1:1] slice would be empty.
    always_comb begin
        result_shift = (result_q >> 1) | (WIDTH'(ha_sum) << (WIDTH - 1));
    end

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        sum_d    = sum_q;
        bit_d    = bit_q;
        cy_d     = cy_q;
        s0_d     = s0_q;
        c0_d     = c0_q;
        cout_d   = cout_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        ha_a     = 1'b0;
        ha_b     = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    opa_d    = in_a;
                    opb_d    = in_b;
                    cy_d     = in_cin;
                    bit_d    = '0;
                    result_d = '0;
                    state_d  = ADD_AB;
                end
            end
            ADD_AB: begin
                busy    = 1'b1;
                ha_a    = opa_q[0];
                ha_b    = opb_q[0];
                s0_d    = ha_sum;
                c0_d    = ha_carry;
                state_d = ADD_CIN;
            end
            ADD_CIN: begin
                busy     = 1'b1;
                ha_a     = s0_q;
                ha_b     = cy_q;
                result_d = result_shift;
                cy_d     = c0_q | ha_carry;
                opa_d    = opa_q >> 1;
                opb_d    = opb_q >> 1;
                bit_d    = bit_q + 1'b1;
                if (bit_q == LAST_BIT) begin
                    // Output copy keeps the result visible after handoff while the next add runs.
                    sum_d   = result_shift;
                    cout_d  = c0_q | ha_carry;
                    state_d = DONE;
                end else begin
                    state_d = ADD_AB;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            sum_q    <= '0;
            bit_q    <= '0;
            cy_q     <= 1'b0;
            s0_q     <= 1'b0;
            c0_q     <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            sum_q    <= sum_d;
            bit_q    <= bit_d;
            cy_q     <= cy_d;
            s0_q     <= s0_d;
            c0_q     <= c0_d;
            cout_q   <= cout_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_ha_serial_add_ctrl.sv
// Self-checking bench: directed vector table, async-reset abort sequence, random scoreboard.
module tb_ha_serial_add_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_cin;
    logic [W-1:0] in_a, in_b, out_sum;
    logic         out_valid, out_ready, out_cout, busy;
    logic         ha_a, ha_b, ha_sum, ha_carry;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] prev_sum;
    logic         prev_cout;

    always #5 clk = ~clk;

    assign ha_sum   = ha_a ^ ha_b;
    assign ha_carry = ha_a & ha_b;

    ha_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy),
        .ha_a(ha_a), .ha_b(ha_b), .ha_sum(ha_sum), .ha_carry(ha_carry)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        int           hold;
        bit           garble;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ha"}, 32'({ha_a, ha_b}), 32'd0);
    endtask

    // One full transaction; the pass schedule and result come from ripple-carry arithmetic.
    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic [W-1:0] exp_sum, input logic exp_cout,
                           input int hold, input bit garble);
        logic [1:0]   t;
        logic         c;
        int unsigned  n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        c = cin;
        for (int unsigned i = 0; i < W; i++) begin
            if (garble) begin
                in_valid = 1'b1;
                in_a = 4'h3;
                in_b = W'($urandom);
                in_cin = ~cin;
            end
            check("pass_ab_ha", 32'({ha_a, ha_b}), 32'({a[i], b[i]}));
            check("busy_ab", 32'({busy, in_ready, out_valid}), 32'b100);
            check("retained_sum", 32'({out_cout, out_sum}), 32'({prev_cout, prev_sum}));
            tick();
            check("pass_cin_ha", 32'({ha_a, ha_b}), 32'({a[i] ^ b[i], c}));
            check("busy_cin", 32'({busy, in_ready, out_valid}), 32'b100);
            tick();
            t = 2'(a[i]) + 2'(b[i]) + 2'(c);
            c = t[1];
        end
        in_valid = 1'b0;
        check("latency_out_valid", 32'(out_valid), 32'd1);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", 32'({out_cout, out_sum}), 32'({exp_cout, exp_sum}));
            tick();
        end
        check("done_sum", 32'(out_sum), 32'(exp_sum));
        check("done_cout", 32'(out_cout), 32'(exp_cout));
        check("done_flags", 32'({in_ready, busy, ha_a, ha_b}), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("after_handoff_valid", 32'(out_valid), 32'd0);
        check("after_handoff_ready", 32'(in_ready), 32'd1);
        check("after_handoff_keep", 32'({out_cout, out_sum}), 32'({exp_cout, exp_sum}));
        prev_sum  = exp_sum;
        prev_cout = exp_cout;
    endtask

    vec_t vecs[$];

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   tot;
        bit           saw_valid;

        vecs.push_back('{a: 4'h7, b: 4'h9, cin: 1'b0, sum: 4'h0, cout: 1'b1, hold: 0, garble: 1'b0});
        vecs.push_back('{a: 4'hF, b: 4'hF, cin: 1'b1, sum: 4'hF, cout: 1'b1, hold: 0, garble: 1'b0});
        vecs.push_back('{a: 4'h0, b: 4'h0, cin: 1'b0, sum: 4'h0, cout: 1'b0, hold: 0, garble: 1'b0});
        vecs.push_back('{a: 4'h1, b: 4'h1, cin: 1'b0, sum: 4'h2, cout: 1'b0, hold: 0, garble: 1'b0});
        vecs.push_back('{a: 4'h8, b: 4'h8, cin: 1'b0, sum: 4'h0, cout: 1'b1, hold: 5, garble: 1'b0});
        vecs.push_back('{a: 4'hA, b: 4'h5, cin: 1'b0, sum: 4'hF, cout: 1'b0, hold: 0, garble: 1'b1});
        vecs.push_back('{a: 4'hF, b: 4'h0, cin: 1'b1, sum: 4'h0, cout: 1'b1, hold: 2, garble: 1'b0});
        vecs.push_back('{a: 4'h3, b: 4'h4, cin: 1'b1, sum: 4'h8, cout: 1'b0, hold: 1, garble: 1'b1});

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0;
        prev_sum = '0; prev_cout = 1'b0;
        #23;
        check_idle_outputs("reset");
        check("reset_result", 32'({out_cout, out_sum}), 32'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            run_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout,
                    vecs[i].hold, vecs[i].garble);
        end

        // Abort mid-add with an asynchronous reset pulse between clock edges.
        in_a = 4'h9; in_b = 4'h9; in_cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        check("async_reset_result", 32'({out_cout, out_sum}), 32'd0);
        #1 rst = 1'b0;
        prev_sum = '0; prev_cout = 1'b0;
        saw_valid = 1'b0;
        for (int unsigned k = 0; k < 12; k++) begin
            tick();
            if (out_valid) saw_valid = 1'b1;
        end
        check("no_valid_after_abort", 32'(saw_valid), 32'd0);
        run_add(4'h5, 4'h6, 1'b0, 4'hB, 1'b0, 0, 1'b0);

        for (int unsigned r = 0; r < 1000; r++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            tot = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
            run_add(ra, rb, rc, tot[W-1:0], tot[W], $urandom_range(0, 2),
                    ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
